// File: rtl/alu_unit.sv
// Multi-cycle 16-bit ALU: one-cycle EXEC ops plus an optional 16-step shift-add multiplier.
// Define ALU_MUL_EN to build the MUL state, iteration counter and multiplier datapath.
module alu_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [15:0] ac_in,
  input  logic [15:0] bus_in,
  output logic [15:0] result,
  output logic        z_flag,
  output logic        c_flag,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] OP_PASS = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_SUB  = 3'b010;
  localparam logic [2:0] OP_AND  = 3'b011;
  localparam logic [2:0] OP_OR   = 3'b100;
  localparam logic [2:0] OP_NOT  = 3'b101;
  localparam logic [2:0] OP_INC  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

`ifdef ALU_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2, S_MUL = 2'd3} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_EXEC = 2'd1, S_DONE = 2'd2} state_t;
`endif

  state_t      state_q, state_d;
  logic [15:0] a_q, b_q;
  logic [2:0]  op_q;
  logic [15:0] result_q;
  logic        z_q, c_q;
  logic [15:0] exec_res;
  logic        exec_c;
  logic [16:0] sum17;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

`ifdef ALU_MUL_EN
  logic [3:0]  cnt_q;
  logic [31:0] prod_q, prod_d, partial;

  // One partial product per edge, selected by the current multiplier bit
  always_comb begin
    partial = b_q[cnt_q] ? ({16'd0, a_q} << cnt_q) : 32'd0;
    prod_d  = prod_q + partial;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 4'd0;
      prod_q <= 32'd0;
    end else if (state_q == S_IDLE && start) begin
      cnt_q  <= 4'd0;
      prod_q <= 32'd0;
    end else if (state_q == S_MUL) begin
      cnt_q  <= cnt_q + 4'd1;
      prod_q <= prod_d;
    end
  end
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef ALU_MUL_EN
          state_d = (op == OP_MUL) ? S_MUL : S_EXEC;
`else
          state_d = S_EXEC;
`endif
        end
      end
      S_EXEC: state_d = S_DONE;
`ifdef ALU_MUL_EN
      S_MUL:  if (cnt_q == 4'd15) state_d = S_DONE;
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  // Single-cycle operations; op 111 lands here only in the multiplier-less build
  always_comb begin
    sum17    = {1'b0, a_q} + {1'b0, b_q};
    exec_res = 16'd0;
    exec_c   = 1'b0;
    case (op_q)
      OP_PASS: exec_res = b_q;
      OP_ADD:  begin exec_res = sum17[15:0]; exec_c = sum17[16]; end
      OP_SUB:  begin exec_res = a_q - b_q;   exec_c = (a_q < b_q); end
      OP_AND:  exec_res = a_q & b_q;
      OP_OR:   exec_res = a_q | b_q;
      OP_NOT:  exec_res = ~a_q;
      OP_INC:  begin exec_res = a_q + 16'd1; exec_c = &a_q; end
      default: begin exec_res = 16'd0; exec_c = 1'b0; end
    endcase
  end

  // Operand latch and result/flag registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= 16'd0;
      b_q      <= 16'd0;
      op_q     <= 3'd0;
      result_q <= 16'd0;
      z_q      <= 1'b0;
      c_q      <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        a_q  <= ac_in;
        b_q  <= bus_in;
        op_q <= op;
      end
      if (state_q == S_EXEC) begin
        result_q <= exec_res;
        z_q      <= (exec_res == 16'd0);
        c_q      <= exec_c;
      end
`ifdef ALU_MUL_EN
      if (state_q == S_MUL && cnt_q == 4'd15) begin
        result_q <= prod_d[15:0];
        z_q      <= (prod_d[15:0] == 16'd0);
        c_q      <= |prod_d[31:16];
      end
`endif
    end
  end

  assign result = result_q;
  assign z_flag = z_q;
  assign c_flag = c_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed cases plus randomized ops against an arithmetic model.
module tb_alu_unit;

`ifdef ALU_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] ac_in, bus_in;
  logic [15:0] result;
  logic        z_flag, c_flag, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  alu_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op),
    .ac_in(ac_in), .bus_in(bus_in), .result(result),
    .z_flag(z_flag), .c_flag(c_flag), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {carry, result}
  function automatic logic [16:0] model(input int a, input int b, input int o);
    int r; int c; longint p;
    r = 0; c = 0;
    case (o)
      0: r = b;
      1: begin r = (a + b) % 65536; c = (a + b > 65535); end
      2: begin r = (a - b + 65536) % 65536; c = (a < b); end
      3: r = a & b;
      4: r = a | b;
      5: r = 65535 - a;
      6: begin r = (a + 1) % 65536; c = (a == 65535); end
      default: begin
        if (MUL_EN) begin
          p = longint'(a) * longint'(b);
          r = int'(p % 65536);
          c = (p >= 65536);
        end
      end
    endcase
    model = {c[0], r[15:0]};
  endfunction

  // Called at a negedge; returns at a negedge with the DUT back in IDLE
  task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                        input int inj, input string tag);
    logic [16:0] e;
    int lat, got, bcnt;
    e   = model(int'(a), int'(b), int'(o));
    lat = (MUL_EN && o == 3'd7) ? 17 : 2;
    ac_in = a; bus_in = b; op = o; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    ac_in = 16'($urandom); bus_in = 16'($urandom); op = 3'($urandom);
    got = 0; bcnt = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (k == inj && inj < lat) begin
        start = 1'b1; op = 3'd1;
        ac_in = 16'($urandom); bus_in = 16'($urandom);
      end else start = 1'b0;
      if (busy) bcnt++;
      if (done) begin got = k; break; end
    end
    start = 1'b0;
    check({tag, ".lat"},  got, lat);
    check({tag, ".busy"}, bcnt, lat);
    check({tag, ".res"},  result, {16'd0, e[15:0]});
    check({tag, ".z"},    z_flag, (e[15:0] == 16'd0));
    check({tag, ".c"},    c_flag, e[16]);
    @(negedge clk);
    check({tag, ".done_pulse"}, {busy, done}, 2'b00);
    check({tag, ".hold"}, result, {16'd0, e[15:0]});
  endtask

  task automatic reset_mid(input logic [15:0] a, input logic [15:0] b, input logic [2:0] o,
                           input int k_rst);
    int dcnt;
    ac_in = a; bus_in = b; op = o; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= k_rst; k++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rstmid.res", result, 16'd0);
    check("rstmid.flags", {z_flag, c_flag, busy, done}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("rstmid.no_done", dcnt, 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'd0; ac_in = 16'd0; bus_in = 16'd0;
    #1;
    check("reset.res", result, 16'd0);
    check("reset.flags", {z_flag, c_flag, busy, done}, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    run_op(16'd16, 16'd32, 3'd1, 0, "add");
    run_op(16'd5, 16'd7, 3'd2, 0, "sub");
    run_op(16'h00F0, 16'h0F00, 3'd3, 0, "and");
    run_op(16'hFFFF, 16'd0, 3'd6, 0, "inc");
    run_op(16'd1, 16'd64, 3'd0, 1, "pass");
    run_op(16'h1200, 16'h0034, 3'd4, 0, "or");
    run_op(16'h00FF, 16'd0, 3'd5, 0, "not");
    run_op(16'hFFFF, 16'd1, 3'd1, 0, "add_carry");
    run_op(16'd300, 16'd300, 3'd7, 5, "mul300");
    run_op(16'd3, 16'd4, 3'd7, 0, "mul3x4");
    run_op(16'hFFFF, 16'hFFFF, 3'd7, 0, "mulmax");

    reset_mid(16'h1234, 16'd7, 3'd7, MUL_EN ? 8 : 1);
    run_op(16'd100, 16'd23, 3'd1, 0, "add_after_rst");
    reset_mid(16'd9, 16'd9, 3'd1, 1);
    run_op(16'd9, 16'd9, 3'd2, 0, "sub_after_rst");

    for (int i = 0; i < 40; i++)
      run_op(16'($urandom), 16'($urandom), 3'($urandom), int'($urandom_range(0, 16)), "rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
